// File: rtl/data_bus_mmio.sv
// data_bus_mmio -- core data-bus bridge to a 1-cycle RAM and a small MMIO
// register window (seven-segment value, LEDs, board inputs, free-running
// counter with compare/interrupt).
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   bus_addr          core byte address
//   bus_wr_data       write data
//   bus_mask          byte enables (writes only; reads ignore them)
//   bus_wr_en         1 = write, 0 = read
//   bus_req           request, held by the core until bus_ack
//   bus_ack           single-cycle completion strobe
//   bus_rd_data       read data, held until the next read completes
//   ram_*             word-addressed RAM port, registered read data
//   sw, key           raw asynchronous board inputs
//   sevseg, led       display / LED registers
//   timer_irq         registered (COUNT >= CMP)
//   bus_err           sticky flag, set by any unmapped access
module data_bus_mmio #(
  parameter int unsigned RAM_ADDR_W = 10,
  parameter logic [31:0] IO_BASE    = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           bus_addr,
  input  logic [31:0]           bus_wr_data,
  input  logic [3:0]            bus_mask,
  input  logic                  bus_wr_en,
  input  logic                  bus_req,
  output logic                  bus_ack,
  output logic [31:0]           bus_rd_data,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [31:0]           ram_wr_data,
  output logic [3:0]            ram_byteena,
  output logic                  ram_wren,
  input  logic [31:0]           ram_rd_data,
  input  logic [9:0]            sw,
  input  logic [3:0]            key,
  output logic [31:0]           sevseg,
  output logic [7:0]            led,
  output logic                  timer_irq,
  output logic                  bus_err
);

  typedef enum logic [1:0] {IDLE, RAM_WAIT, ACK} state_t;

  // Word index inside the register window.
  localparam logic [2:0] REG_SEVSEG = 3'd0;
  localparam logic [2:0] REG_LED    = 3'd1;
  localparam logic [2:0] REG_INPUT  = 3'd2;
  localparam logic [2:0] REG_COUNT  = 3'd3;
  localparam logic [2:0] REG_CMP    = 3'd4;

  typedef struct packed {
    logic       ram;
    logic       io;
    logic       unmapped;
    logic [2:0] idx;
  } dec_t;

  state_t       state, state_nxt;
  dec_t         dec;
  logic [29:0]  io_word;
  logic         txn_start;
  logic         reg_wr, reg_rd;
  logic [31:0]  reg_rdata;
  logic [31:0]  count, cmp;
  // Two-flop synchroniser for {key, sw}; entry [1] is the safe copy.
  logic [1:0][13:0] in_sync;

  // ---------------------------------------------------------------- decode
  // Low two address bits are ignored for both RAM and registers (word
  // access); the register window is five words starting at IO_BASE.
  assign io_word = bus_addr[31:2] - IO_BASE[31:2];

  always_comb begin
    dec          = '0;
    dec.ram      = (bus_addr[31:RAM_ADDR_W+2] == '0);
    dec.io       = !dec.ram && (io_word[29:3] == '0) && (io_word[2:0] <= REG_CMP);
    dec.unmapped = !dec.ram && !dec.io;
    dec.idx      = io_word[2:0];
  end

  // A transaction is only accepted from IDLE; req in RAM_WAIT/ACK is ignored.
  assign txn_start = (state == IDLE) && bus_req;
  assign reg_wr    = txn_start && dec.io && bus_wr_en;
  assign reg_rd    = txn_start && dec.io && !bus_wr_en;

  // ---------------------------------------------------------------- RAM port
  assign ram_addr    = bus_addr[RAM_ADDR_W+1:2];
  assign ram_wr_data = bus_wr_data;
  assign ram_byteena = bus_mask;
  // Write strobe lasts only the IDLE cycle; state leaves IDLE on the next edge.
  assign ram_wren    = txn_start && bus_wr_en && dec.ram && !rst;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (bus_req) state_nxt = (dec.ram && !bus_wr_en) ? RAM_WAIT : ACK;
      RAM_WAIT: state_nxt = ACK;
      ACK:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Gated by rst so a transaction caught by reset in ACK never shows an ack.
  assign bus_ack = (state == ACK) && !rst;

  // ---------------------------------------------------------------- registers
  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  always_comb begin
    reg_rdata = '0;
    case (dec.idx)
      REG_SEVSEG: reg_rdata = sevseg;
      REG_LED:    reg_rdata = {24'd0, led};
      REG_INPUT:  reg_rdata = {18'd0, in_sync[1]};
      REG_COUNT:  reg_rdata = count;
      REG_CMP:    reg_rdata = cmp;
      default:    reg_rdata = '0;
    endcase
  end

  // Writable registers; INPUT and COUNT simply have no write path.
  always_ff @(posedge clk) begin
    if (rst) begin
      sevseg <= '0;
      led    <= '0;
      cmp    <= 32'hFFFF_FFFF;
    end else if (reg_wr) begin
      case (dec.idx)
        REG_SEVSEG: sevseg <= byte_merge(sevseg, bus_wr_data, bus_mask);
        REG_LED:    if (bus_mask[0]) led <= bus_wr_data[7:0];
        REG_CMP:    cmp    <= byte_merge(cmp, bus_wr_data, bus_mask);
        default:    ;
      endcase
    end
  end

  // Free-running counter and compare interrupt, independent of the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      timer_irq <= 1'b0;
    end else begin
      count     <= count + 32'd1;
      timer_irq <= (count >= cmp);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) in_sync <= '0;
    else     in_sync <= {in_sync[0], {key, sw}};
  end

  // ---------------------------------------------------------------- read data / error
  // Only reads touch bus_rd_data: registers and unmapped reads at the IDLE
  // edge, RAM at the RAM_WAIT edge once the registered RAM output is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_rd_data <= '0;
    end else if (reg_rd) begin
      bus_rd_data <= reg_rdata;
    end else if (state == RAM_WAIT) begin
      bus_rd_data <= ram_rd_data;
    end else if (txn_start && dec.unmapped && !bus_wr_en) begin
      bus_rd_data <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                          bus_err <= 1'b0;
    else if (txn_start && dec.unmapped) bus_err <= 1'b1;
  end

endmodule

// File: tb/tb_data_bus_mmio.sv
// Directed bench for data_bus_mmio: a behavioural 1-cycle RAM sits on the
// RAM port, expected read data is queued when a read is issued and popped
// when its ack arrives.
module tb_data_bus_mmio;
  localparam int unsigned RAM_ADDR_W = 10;
  localparam logic [31:0] IO_BASE    = 32'h8000_0000;
  localparam logic [31:0] RAM_BYTES  = 32'd4 << RAM_ADDR_W;
  localparam logic [31:0] A_SEV = IO_BASE;
  localparam logic [31:0] A_LED = IO_BASE + 32'h04;
  localparam logic [31:0] A_IN  = IO_BASE + 32'h08;
  localparam logic [31:0] A_CNT = IO_BASE + 32'h0C;
  localparam logic [31:0] A_CMP = IO_BASE + 32'h10;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] bus_addr, bus_wr_data, bus_rd_data;
  logic [3:0]  bus_mask;
  logic        bus_wr_en, bus_req, bus_ack;
  logic [RAM_ADDR_W-1:0] ram_addr;
  logic [31:0] ram_wr_data, ram_rd_data;
  logic [3:0]  ram_byteena;
  logic        ram_wren;
  logic [9:0]  sw;
  logic [3:0]  key;
  logic [31:0] sevseg;
  logic [7:0]  led;
  logic        timer_irq, bus_err;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  data_bus_mmio #(.RAM_ADDR_W(RAM_ADDR_W), .IO_BASE(IO_BASE)) dut (
    .clk(clk), .rst(rst),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_mask(bus_mask),
    .bus_wr_en(bus_wr_en), .bus_req(bus_req), .bus_ack(bus_ack),
    .bus_rd_data(bus_rd_data),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_byteena(ram_byteena),
    .ram_wren(ram_wren), .ram_rd_data(ram_rd_data),
    .sw(sw), .key(key), .sevseg(sevseg), .led(led),
    .timer_irq(timer_irq), .bus_err(bus_err)
  );

  // Synchronous RAM with byte enables and registered read.
  logic [31:0] mem [1 << RAM_ADDR_W];
  always @(posedge clk) begin
    if (ram_wren)
      for (int i = 0; i < 4; i++)
        if (ram_byteena[i]) mem[ram_addr][i*8 +: 8] <= ram_wr_data[i*8 +: 8];
    ram_rd_data <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus transaction: drive, wait for ack (bounded), check latency,
  // write-strobe count, read data or read-data hold, and ack width.
  task automatic txn(input string tag, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] m, input logic we, input int exp_lat,
                     input bit use_sb, output logic [31:0] rdata);
    int lat, wc;
    logic [31:0] held, exp;
    @(posedge clk); #1;
    held = bus_rd_data;
    bus_addr = a; bus_wr_data = d; bus_mask = m; bus_wr_en = we; bus_req = 1'b1;
    #1;
    chk({tag, "/ram_wr_data"}, ram_wr_data, d);
    chk({tag, "/ram_byteena"}, {28'd0, ram_byteena}, {28'd0, m});
    if (a < RAM_BYTES) chk({tag, "/ram_addr"}, 32'(ram_addr), 32'(a[RAM_ADDR_W+1:2]));
    lat = 0; wc = 0;
    forever begin
      @(negedge clk);
      if (ram_wren) wc++;
      if (bus_ack || lat >= 8) break;
      lat++;
    end
    chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "/wren_cycles"}, 32'(wc), (we && a < RAM_BYTES) ? 32'd1 : 32'd0);
    rdata = bus_rd_data;
    if (we) chk({tag, "/rd_hold"}, bus_rd_data, held);
    else if (use_sb) begin
      exp = sb_q.pop_front();
      chk({tag, "/rd_data"}, bus_rd_data, exp);
    end
    @(posedge clk); #1;
    bus_req = 1'b0; bus_wr_en = 1'b0;
    @(negedge clk);
    chk({tag, "/ack_width"}, 32'(bus_ack), 32'd0);
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp, input int lat);
    logic [31:0] v;
    sb_q.push_back(exp);
    txn(tag, a, 32'd0, 4'd0, 1'b0, lat, 1'b1, v);
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] m, input int lat);
    logic [31:0] v;
    txn(tag, a, d, m, 1'b1, lat, 1'b0, v);
  endtask

  task automatic rd_raw(input string tag, input logic [31:0] a, output logic [31:0] v);
    txn(tag, a, 32'd0, 4'd0, 1'b0, 1, 1'b0, v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c1, c2;
    logic [31:0] v [3];
    logic [5:0]  pat;
    int n, k;

    rst = 1'b1; bus_req = 1'b0; bus_wr_en = 1'b0; bus_addr = '0;
    bus_wr_data = '0; bus_mask = '0; sw = '0; key = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst/ack", 32'(bus_ack), 32'd0);
    chk("rst/rd_data", bus_rd_data, 32'd0);
    chk("rst/sevseg", sevseg, 32'd0);
    chk("rst/led", 32'(led), 32'd0);
    chk("rst/irq", 32'(timer_irq), 32'd0);
    chk("rst/err", 32'(bus_err), 32'd0);

    // Timer: CMP=5 right after reset; irq rises when COUNT reaches 5.
    wr("cmp5", A_CMP, 32'd5, 4'hF, 1);
    chk("irq_before", 32'(timer_irq), 32'd0);
    n = 0;
    while (!timer_irq && n < 10) begin @(negedge clk); n++; end
    chk("irq_rise_delay", 32'(n), 32'd3);
    wr("cmp_max", A_CMP, 32'hFFFF_FFFF, 4'hF, 1);
    chk("irq_cleared", 32'(timer_irq), 32'd0);

    // Back-to-back COUNT reads with bus_req held.
    @(posedge clk); #1;
    bus_addr = A_CNT; bus_wr_en = 1'b0; bus_mask = 4'd0; bus_req = 1'b1;
    k = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat[i] = bus_ack;
      if (bus_ack && k < 3) begin v[k] = bus_rd_data; k++; end
    end
    @(posedge clk); #1 bus_req = 1'b0;
    chk("b2b/ack_pattern", 32'(pat), 32'(6'b101010));
    chk("b2b/count_step1", v[1] - v[0], 32'd2);
    chk("b2b/count_step2", v[2] - v[1], 32'd2);

    // RAM write then read; partial write; last RAM word.
    wr("ram_wr", 32'h010, 32'h1234_5678, 4'hF, 1);
    rd("ram_rd", 32'h010, 32'h1234_5678, 2);
    wr("ram_wr_part", 32'h010, 32'hFFFF_FFFF, 4'b0011, 1);
    rd("ram_rd_part", 32'h010, 32'h1234_FFFF, 2);
    wr("ram_wr_top", RAM_BYTES - 4, 32'hCAFE_F00D, 4'hF, 1);
    rd("ram_rd_top", RAM_BYTES - 4, 32'hCAFE_F00D, 2);

    // SEVSEG byte masking.
    wr("sev_wr", A_SEV, 32'hAABB_CCDD, 4'b0101, 1);
    chk("sev_val", sevseg, 32'h00BB_00DD);
    wr("sev_mask0", A_SEV, 32'hFFFF_FFFF, 4'b0000, 1);
    rd("sev_rd", A_SEV, 32'h00BB_00DD, 1);
    wr("sev_wr2", A_SEV, 32'h1122_3344, 4'b1010, 1);
    rd("sev_rd2", A_SEV, 32'h11BB_33DD, 1);

    // LED: only byte 0 exists.
    wr("led_wr", A_LED, 32'h0000_01A5, 4'hF, 1);
    chk("led_val", 32'(led), 32'h0000_00A5);
    wr("led_wr_hi", A_LED, 32'hFFFF_FF00, 4'b1110, 1);
    rd("led_rd", A_LED, 32'h0000_00A5, 1);

    // Synchronised inputs; writes to INPUT / COUNT are ignored.
    sw = 10'h2A5; key = 4'hA;
    repeat (2) @(posedge clk);
    rd("input_rd", A_IN, 32'h0000_2AA5, 1);
    wr("input_wr", A_IN, 32'hFFFF_FFFF, 4'hF, 1);
    rd("input_rd2", A_IN, 32'h0000_2AA5, 1);
    rd_raw("cnt_a", A_CNT, c1);
    wr("cnt_wr", A_CNT, 32'd0, 4'hF, 1);
    rd_raw("cnt_b", A_CNT, c2);
    chk("count_ignores_write", c2 - c1, 32'd6);

    // Unmapped accesses and sticky error.
    chk("err_before", 32'(bus_err), 32'd0);
    rd("unmapped_rd", 32'h4000_0000, 32'd0, 1);
    chk("err_set", 32'(bus_err), 32'd1);
    rd("ram_end_unmapped", RAM_BYTES, 32'd0, 1);
    wr("io_end_unmapped", IO_BASE + 32'h14, 32'hDEAD_BEEF, 4'hF, 1);
    rd("sev_after_err", A_SEV, 32'h11BB_33DD, 1);
    chk("err_held", 32'(bus_err), 32'd1);

    // Reset while a RAM read sits in RAM_WAIT.
    @(posedge clk); #1;
    bus_addr = 32'h010; bus_wr_en = 1'b0; bus_mask = 4'hF; bus_req = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rstmid/ack_wait", 32'(bus_ack), 32'd0);
    @(posedge clk); #1;
    bus_wr_en = 1'b1; bus_wr_data = 32'h5555_5555;
    @(negedge clk);
    chk("rstmid/wren_in_rst", 32'(ram_wren), 32'd0);
    chk("rstmid/ack_rst", 32'(bus_ack), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; bus_req = 1'b0; bus_wr_en = 1'b0;
    @(negedge clk);
    chk("rstmid/ack", 32'(bus_ack), 32'd0);
    chk("rstmid/rd_data", bus_rd_data, 32'd0);
    chk("rstmid/sevseg", sevseg, 32'd0);
    chk("rstmid/led", 32'(led), 32'd0);
    chk("rstmid/irq", 32'(timer_irq), 32'd0);
    chk("rstmid/err", 32'(bus_err), 32'd0);
    rd("rstmid/ram_rd", 32'h010, 32'h1234_FFFF, 2);
    rd("rstmid/cmp", A_CMP, 32'hFFFF_FFFF, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_bus_mmio.md
DATA_BUS_MMIO -- requirements
Module: data_bus_mmio

Interface
REQ-001 SHALL have parameter RAM_ADDR_W, default 10, RAM word-address width (4 KiB RAM).
REQ-002 SHALL have parameter IO_BASE, default 32'h8000_0000, base address of the register window.
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-004 SHALL have ports bus_addr in 32 (core byte address), bus_wr_data in 32, bus_mask in 4 (byte enables) and bus_wr_en in 1.
REQ-005 SHALL have ports bus_req in 1 (held until ack), bus_ack out 1 (single-cycle) and bus_rd_data out 32.
REQ-006 SHALL have ports ram_addr out RAM_ADDR_W (= bus_addr[RAM_ADDR_W+1:2]), ram_wr_data out 32, ram_byteena out 4, ram_wren out 1 and ram_rd_data in 32 (1-cycle registered RAM read).
REQ-007 SHALL have ports sw in 10 and key in 4 (raw board inputs, asynchronous).
REQ-008 SHALL have ports sevseg out 32 (display value), led out 8 (LEDR[7:0]), timer_irq out 1 and bus_err out 1 (sticky unmapped-access flag).

Function
REQ-009 SHALL decode addresses as follows: RAM when bus_addr < 4*2^RAM_ADDR_W; register window at IO_BASE+{0x00 SEVSEG rw, 0x04 LED rw [7:0], 0x08 INPUT ro {18'b0,key,sw} synchronised, 0x0C COUNT ro, 0x10 CMP rw}; everything else unmapped.
REQ-010 SHALL use an FSM with states IDLE, RAM_WAIT and ACK; bus_req is sampled only in IDLE.
REQ-011 SHALL handle a RAM read as IDLE (address driven) -> RAM_WAIT -> ACK, with bus_ack high in ACK and bus_rd_data = ram_rd_data latched in RAM_WAIT; latency from req to ack is 2 cycles.
REQ-012 SHALL handle a RAM write with ram_wren = bus_req & bus_wr_en & ram_sel & (state==IDLE) & ~rst, combinational for exactly one cycle, then IDLE -> ACK; latency is 1 cycle.
REQ-013 SHALL handle a register access as IDLE -> ACK; latency is 1 cycle. Writes update the register at the IDLE edge; read data is registered into bus_rd_data at the same edge.
REQ-014 SHALL apply register writes with byte granularity: byte i updates only when bus_mask[i]=1; bus_mask=0 still acks with no change. Reads ignore bus_mask.
REQ-015 SHALL ignore writes to INPUT and COUNT and still ack them.
REQ-016 SHALL handle an unmapped access by acking after 1 cycle, returning read data 0, performing no write and setting bus_err=1 until reset.
REQ-017 SHALL drive bus_ack high for exactly one cycle per transaction and low in all other states. ACK always returns to IDLE; bus_req high in ACK is ignored, giving a one-cycle bubble before the next transaction.
REQ-018 SHALL hold bus_rd_data from the last read until the next read completes; writes do not alter it.
REQ-019 SHALL pass ram_wr_data = bus_wr_data and ram_byteena = bus_mask through combinationally.
REQ-020 SHALL increment COUNT by 1 every clock cycle, wrapping 0xFFFF_FFFF -> 0. A write to CMP in the same cycle does not disturb COUNT.
REQ-021 SHALL register timer_irq as timer_irq <= (COUNT >= CMP), unsigned, recomputed every cycle. Writing CMP above COUNT clears it on the cycle after the write.
REQ-022 SHALL synchronise sw and key through 2 flops each, so an input change is visible in INPUT 2 cycles later.

Reset
REQ-023 SHALL, when rst=1 at a clock edge, set state=IDLE, bus_ack=0, bus_rd_data=0, sevseg=0, led=0, COUNT=0, CMP=0xFFFF_FFFF, timer_irq=0, bus_err=0 and input sync flops=0.
REQ-024 SHALL, on reset mid-transaction (RAM_WAIT/ACK), abandon the transaction with no ack issued; ram_wren is 0 during any reset cycle.
REQ-025 SHALL, after reset release, accept a new transaction on the first cycle with bus_req=1.

Verification
REQ-026 SHALL verify: write 0x1234_5678 with mask 4'b1111 to RAM 0x010, then read 0x010 -> ram_wren pulses 1 cycle, write ack at +1, read ack at +2 with rd_data 0x1234_5678.
REQ-027 SHALL verify: write 0xAABB_CCDD with mask 4'b0101 to IO_BASE+0 when sevseg=0 -> sevseg=0x00BB_00DD, ack at +1, ram_wren stays 0.
REQ-028 SHALL verify: read 0x4000_0000 -> ack at +1, rd_data=0, bus_err=1 and held through later valid accesses until rst.
REQ-029 SHALL verify: write CMP=5 after reset -> timer_irq rises once COUNT>=5; then write CMP=0xFFFF_FFFF -> timer_irq=0 one cycle later.
REQ-030 SHALL verify: assert rst in the RAM_WAIT state -> no ack, state=IDLE, all REQ-023 values; the next read after release completes in 2 cycles.
REQ-031 SHALL verify: hold bus_req continuously for back-to-back IO reads -> acks are separated by exactly one idle cycle, and each ack is exactly one cycle wide.
